// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display: segment
// encoding table and the idle (all-off) patterns for SEG and ANODO.
package display_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] ANODO_OFF = 8'hFF;

   // Active-low a..g per hex value; element 0 is the rightmost entry.
   localparam logic [15:0][6:0] HEX_SEG7 = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low segment code; bit0 carries the
// inverted decimal-point request, which survives blanking.
module hex_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg = {(blank ? 7'h7F : HEX_SEG7[nibble]), ~dp};
   end

endmodule

// File: rtl/display_mux_param.sv
// Time-multiplexed seven-segment driver with frame-synchronous shadow
// registers, PWM brightness and leading-zero blanking.
module display_mux_param
   import display_pkg::*;
#(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int BRIGHT_W    = 4
) (
   input  logic                    clk_display,
   input  logic                    reset,
   input  logic [4*N_DIGITS-1:0]   numero_entrada,
   input  logic                    power_on,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     digit_en,
   input  logic                    blank_lz,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [7:0]              SEG,
   output logic [N_DIGITS-1:0]     ANODO,
   output logic                    frame_tick
);

   if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_n_digits
      $error("display_mux_param: N_DIGITS must be in 1..8");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("display_mux_param: REFRESH_DIV must be >= 2");
   end
   if (BRIGHT_W < 1 || BRIGHT_W > 8) begin : g_bad_bright_w
      $error("display_mux_param: BRIGHT_W must be in 1..8");
   end

   localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] ANODO_IDLE = ANODO_OFF[N_DIGITS-1:0];

   logic [PRESC_W-1:0]    presc;
   logic [IDX_W-1:0]      idx;
   logic [BRIGHT_W-1:0]   pwm_cnt;

   logic [4*N_DIGITS-1:0] num_sh;
   logic [N_DIGITS-1:0]   dp_sh;
   logic [N_DIGITS-1:0]   en_sh;
   logic                  blank_lz_sh;

   logic                  slot_tick;
   logic                  frame_wrap;
   logic [N_DIGITS:0]     zero_from;
   logic [3:0]            nibble_cur;
   logic                  dp_cur;
   logic                  en_cur;
   logic                  lz_cur;
   logic                  pwm_lit;
   logic [N_DIGITS-1:0]   anodo_sel;
   logic [7:0]            seg_code;

   always_comb begin
      slot_tick  = (presc == PRESC_LAST);
      frame_wrap = slot_tick && (idx == IDX_LAST);
      pwm_lit    = (pwm_cnt <= brightness);
      anodo_sel  = ~(N_DIGITS'(1) << idx);
   end

   // zero_from[i]: shadow nibbles i..N_DIGITS-1 are all zero.
   always_comb begin
      zero_from = '0;
      zero_from[N_DIGITS] = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (num_sh[4*i +: 4] == 4'h0);
      end
   end

   always_comb begin
      nibble_cur = 4'h0;
      dp_cur     = 1'b0;
      en_cur     = 1'b0;
      lz_cur     = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nibble_cur = num_sh[4*i +: 4];
            dp_cur     = dp_sh[i];
            en_cur     = en_sh[i];
            lz_cur     = blank_lz_sh && (i != 0) && zero_from[i];
         end
      end
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble_cur),
      .dp     (dp_cur),
      .blank  (lz_cur),
      .seg    (seg_code)
   );

   // Shadow copies change only at the index wrap so a frame never tears;
   // power_on and brightness are deliberately taken live.
   always_ff @(posedge clk_display) begin
      if (reset) begin
         presc       <= '0;
         idx         <= '0;
         pwm_cnt     <= '0;
         num_sh      <= '0;
         dp_sh       <= '0;
         en_sh       <= '0;
         blank_lz_sh <= 1'b0;
         frame_tick  <= 1'b0;
         SEG         <= SEG_BLANK;
         ANODO       <= ANODO_IDLE;
      end else begin
         presc   <= slot_tick ? '0 : presc + 1'b1;
         pwm_cnt <= pwm_cnt + 1'b1;
         if (slot_tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         frame_tick <= frame_wrap;
         if (frame_wrap) begin
            num_sh      <= numero_entrada;
            dp_sh       <= dp_in;
            en_sh       <= digit_en;
            blank_lz_sh <= blank_lz;
         end
         SEG   <= power_on ? seg_code : SEG_BLANK;
         ANODO <= (power_on && en_cur && pwm_lit) ? anodo_sel : ANODO_IDLE;
      end
   end

endmodule

// File: tb/tb_display_mux_param.sv
// Directed bench for display_mux_param: scan walk, shadow timing, blanking,
// masking, power gating, reset abort and PWM duty.
module tb_display_mux_param;

   logic        clk_display = 1'b0;
   logic        reset;
   logic [31:0] numero_entrada;
   logic        power_on;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic        blank_lz;
   logic [3:0]  brightness;

   logic [7:0]  seg;
   logic [7:0]  anodo;
   logic        frame_tick;
   logic [7:0]  seg_pwm;
   logic [7:0]  anodo_pwm;
   logic        frame_tick_pwm;

   int n_cmp  = 0;
   int n_fail = 0;

   // Digit order 0..7 for 32'h89ABCDEF, dp off.
   logic [7:0] exp_walk [8] = '{8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01};
   // blank_lz=1, 32'h00000050, dp_in=8'h04.
   logic [7:0] exp_lz [8]   = '{8'h03, 8'h49, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   always #5 clk_display = ~clk_display;

   display_mux_param #(.N_DIGITS(8), .REFRESH_DIV(4), .BRIGHT_W(4)) dut (
      .clk_display    (clk_display),
      .reset          (reset),
      .numero_entrada (numero_entrada),
      .power_on       (power_on),
      .dp_in          (dp_in),
      .digit_en       (digit_en),
      .blank_lz       (blank_lz),
      .brightness     (brightness),
      .SEG            (seg),
      .ANODO          (anodo),
      .frame_tick     (frame_tick)
   );

   display_mux_param #(.N_DIGITS(8), .REFRESH_DIV(64), .BRIGHT_W(4)) dut_pwm (
      .clk_display    (clk_display),
      .reset          (reset),
      .numero_entrada (numero_entrada),
      .power_on       (power_on),
      .dp_in          (dp_in),
      .digit_en       (digit_en),
      .blank_lz       (blank_lz),
      .brightness     (brightness),
      .SEG            (seg_pwm),
      .ANODO          (anodo_pwm),
      .frame_tick     (frame_tick_pwm)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_display);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame(input int budget);
      int k;
      k = 0;
      do begin
         tick(1);
         k++;
      end while (frame_tick !== 1'b1 && k < budget);
      check("frame_wait", {7'b0, frame_tick}, 8'h01);
   endtask

   task automatic wait_frame_pwm(input int budget);
      int k;
      k = 0;
      do begin
         tick(1);
         k++;
      end while (frame_tick_pwm !== 1'b1 && k < budget);
      check("frame_wait_pwm", {7'b0, frame_tick_pwm}, 8'h01);
   endtask

   initial begin
      logic [7:0] exp_an;
      int lit;

      reset          = 1'b1;
      numero_entrada = 32'h0;
      power_on       = 1'b0;
      dp_in          = 8'h00;
      digit_en       = 8'h00;
      blank_lz       = 1'b0;
      brightness     = 4'h0;
      tick(2);
      check("reset_seg", seg, 8'hFF);
      check("reset_anodo", anodo, 8'hFF);
      check("reset_frame_tick", {7'b0, frame_tick}, 8'h00);

      // Scan walk: digits masked with zero data until the first shadow load.
      numero_entrada = 32'h89ABCDEF;
      digit_en       = 8'hFF;
      brightness     = 4'hF;
      power_on       = 1'b1;
      reset          = 1'b0;
      tick(1);
      check("premask_anodo", anodo, 8'hFF);
      check("premask_seg", seg, 8'h03);
      wait_frame(100);
      check("first_frame_anodo", anodo, 8'hFF);
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 4; c++) begin
            tick(1);
            exp_an = ~(8'h01 << d);
            check($sformatf("walk_anodo d%0d c%0d", d, c), anodo, exp_an);
            check($sformatf("walk_seg d%0d c%0d", d, c), seg, exp_walk[d]);
            check($sformatf("walk_ft d%0d c%0d", d, c), {7'b0, frame_tick},
                  (d == 7 && c == 3) ? 8'h01 : 8'h00);
         end
      end

      // Mid-frame input change is held off until the next frame.
      numero_entrada = 32'h11111111;
      wait_frame(100);
      tick(16);
      numero_entrada = 32'h22222222;
      for (int j = 0; j < 16; j++) begin
         tick(1);
         check($sformatf("no_tear_seg %0d", j), seg, 8'h9F);
      end
      check("tear_frame_tick", {7'b0, frame_tick}, 8'h01);
      tick(1);
      check("new_frame_seg", seg, 8'h25);

      // Leading-zero blanking with a decimal point on a blanked digit.
      blank_lz       = 1'b1;
      numero_entrada = 32'h00000050;
      dp_in          = 8'h04;
      wait_frame(100);
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 4; c++) begin
            tick(1);
            check($sformatf("lz_seg d%0d c%0d", d, c), seg, exp_lz[d]);
         end
      end

      // Digit mask: upper four digits never selected.
      blank_lz = 1'b0;
      dp_in    = 8'h00;
      digit_en = 8'h0F;
      wait_frame(100);
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 4; c++) begin
            tick(1);
            exp_an = (d < 4) ? ~(8'h01 << d) : 8'hFF;
            check($sformatf("mask_anodo d%0d c%0d", d, c), anodo, exp_an);
         end
      end

      // power_on gates outputs next cycle while the counters keep running.
      tick(1);
      power_on = 1'b0;
      digit_en = 8'hFF;
      tick(1);
      check("power_off_anodo", anodo, 8'hFF);
      check("power_off_seg", seg, 8'hFF);
      power_on = 1'b1;
      tick(1);
      check("power_on_anodo", anodo, 8'hFE);
      check("power_on_seg", seg, 8'h03);
      tick(29);
      check("power_frame_tick", {7'b0, frame_tick}, 8'h01);

      // Reset mid-slot at index 5 aborts the frame.
      tick(22);
      check("pre_reset_anodo", anodo, 8'hDF);
      reset = 1'b1;
      tick(1);
      check("mid_reset_anodo", anodo, 8'hFF);
      check("mid_reset_seg", seg, 8'hFF);
      check("mid_reset_ft", {7'b0, frame_tick}, 8'h00);
      tick(1);
      reset = 1'b0;
      for (int j = 0; j < 31; j++) begin
         tick(1);
         check($sformatf("post_reset_ft %0d", j), {7'b0, frame_tick}, 8'h00);
         check($sformatf("post_reset_anodo %0d", j), anodo, 8'hFF);
      end
      tick(1);
      check("post_reset_frame", {7'b0, frame_tick}, 8'h01);
      tick(1);
      check("post_reset_digit0", anodo, 8'hFE);
      check("post_reset_seg0", seg, 8'h03);

      // PWM duty on the long-slot instance.
      brightness = 4'h3;
      wait_frame_pwm(1200);
      tick(1);
      lit = 0;
      for (int j = 0; j < 16; j++) begin
         tick(1);
         if (anodo_pwm === 8'hFE) lit++;
      end
      check("pwm_duty_b3", 8'(lit), 8'd4);
      brightness = 4'h0;
      lit = 0;
      for (int j = 0; j < 16; j++) begin
         tick(1);
         if (anodo_pwm === 8'hFE) lit++;
      end
      check("pwm_duty_b0", 8'(lit), 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/display_mux_param.md
DISPLAY_MUX_PARAM -- requirements
Module: display_mux_param

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot (legal >= 2).
REQ-003 SHALL have parameter BRIGHT_W, default 4, brightness control width (legal 1..8).
REQ-004 SHALL have port clk_display  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port numero_entrada  input  4*N_DIGITS  hex nibbles; nibble i drives digit i.
REQ-007 SHALL have port power_on  input  1  display enable; 0 blanks everything.
REQ-008 SHALL have port dp_in  input  N_DIGITS  decimal point request per digit.
REQ-009 SHALL have port digit_en  input  N_DIGITS  per-digit enable mask.
REQ-010 SHALL have port blank_lz  input  1  leading-zero blanking mode.
REQ-011 SHALL have port brightness  input  BRIGHT_W  PWM duty code.
REQ-012 SHALL have port SEG  output  8  active-low segments: bit7..bit1 = a..g, bit0 = dp.
REQ-013 SHALL have port ANODO  output  N_DIGITS  active-low digit select.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse per completed scan frame.

Function
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; slot tick = prescaler at REFRESH_DIV-1.
REQ-016 Digit index SHALL advance by 1 on each slot tick; N_DIGITS-1 wraps to 0; for N_DIGITS=1 it stays 0.
REQ-017 On the edge where the index wraps to 0, shadow register SHALL load numero_entrada, dp_in, digit_en and blank_lz; display SHALL use only shadow values (no mid-frame tearing).
REQ-018 frame_tick SHALL be 1 for exactly the cycle after the shadow-load edge, else 0.
REQ-019 PWM counter (BRIGHT_W bits) SHALL free-run, +1 per clock, wrapping; the digit is lit when pwm_cnt <= brightness; duty = (brightness+1)/2^BRIGHT_W; all-ones = always lit.
REQ-020 Digit i is lz-blanked when shadow blank_lz=1, i != 0 and nibbles i..N_DIGITS-1 are all zero; digit 0 is never lz-blanked.
REQ-021 SEG SHALL be the hex 7-segment code of the current nibble (0 -> 0000001x, 1 -> 1001111x, ..., F -> 0111000x, a..g active-low), or 1111111x when lz-blanked; bit0 = ~dp of the current digit, even when lz-blanked.
REQ-022 ANODO SHALL be all ones except bit[index] = 0, and only when power_on=1, shadow digit_en[index]=1 and the PWM condition holds.
REQ-023 When power_on=0, ANODO SHALL be all ones and SEG SHALL be 8'hFF; counters keep running.
REQ-024 SEG and ANODO SHALL be registered: they reflect index, shadow, PWM and power_on sampled at the previous edge (1-cycle latency).
REQ-025 power_on and brightness SHALL take effect without waiting for a frame boundary.

Reset
REQ-026 While reset=1 at an edge: prescaler, index, pwm_cnt and shadow (including digit_en and blank_lz) SHALL clear to 0; ANODO all ones; SEG 8'hFF; frame_tick 0.
REQ-027 Reset asserted mid-frame SHALL abort the slot; the first shadow load after reset occurs at the first index wrap (display shows zero data with all digits masked until then).

Structure
REQ-028 Shared package display_pkg SHALL hold the 16-entry hex-to-segment table, SEG_BLANK (8'hFF) and ANODO-off constants.
REQ-029 A combinational sub-module hex_to_seg7 (nibble + dp -> SEG code) SHALL be instantiated once.
REQ-030 Illegal parameter values SHALL fail elaboration.

Verification (N_DIGITS=8, REFRESH_DIV=4, BRIGHT_W=4 unless noted)
REQ-031 Reset, then numero_entrada=32'h89ABCDEF, digit_en=FF, brightness=F, power_on=1 -> after the first frame_tick, ANODO walks FE,FD,...,7F with 4 cycles per digit; SEG = 0x71 (F) during FE, 0x01 (8) during 7F.
REQ-032 Change numero_entrada from 32'h11111111 to 32'h22222222 mid-frame -> SEG stays 0x9F until the next frame_tick, then 0x25.
REQ-033 blank_lz=1, numero_entrada=32'h00000050, dp_in=8'h04 -> digits 2..7 SEG = 8'hFF except digit 2 = 8'hFE; digit 1 = 0x49; digit 0 = 0x03.
REQ-034 brightness=4'h3, REFRESH_DIV=64 -> ANODO active 4 of every 16 cycles within each slot; brightness=0 -> 1 of 16.
REQ-035 digit_en=8'h0F -> digits 4..7 never selected; power_on=0 -> ANODO=FF, SEG=FF the next cycle.
REQ-036 Assert reset mid-slot at index 5 -> next cycle ANODO=FF, SEG=FF, frame_tick=0; after release index restarts at 0.
